control_sequencer: RTL and testbench

//  Registered, multi-cycle successor to the combinational instruction decoder.
//  - Latches one instruction per valid/ready handshake and steps it through 1..MAX_CYC execute cycles.
//  - Stretches any memory cycle while mem_ready is low.
//  - Owns interrupt enable/pending state and drives the datapath strobes for the CPU core.

---
 rtl/control_pkg.sv | 22 ++
 rtl/control_decode.sv | 55 +++++
 rtl/control_sequencer.sv | 139 +++++++++++++
 tb/tb_control_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and opcode-class constants for the control sequencer and its decoder.
// The cycle-length helper is the single source of truth for instruction length.
package control_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        IRQ  = 2'd3
    } state_e;

    // Opcode class patterns: MEM matches op[7:6], JMP and SIMPLE match op[7:5]
    localparam logic [1:0] CLS_MEM    = 2'b10;
    localparam logic [2:0] CLS_JMP    = 3'b111;
    localparam logic [2:0] CLS_SIMPLE = 3'b000;

    function automatic int unsigned cyc_len(input logic [7:0] op);
        if (op[7:6] == CLS_MEM || op[7:5] == CLS_JMP) return 2;
        return 1;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode of the latched instruction at the current execute cycle.
// Every output is forced to zero when en_i is low, so idle and interrupt states emit nothing.
module control_decode
    import control_pkg::*;
#(
    parameter int INST_W = 8,
    parameter int CYC_W  = 2,
    parameter int ALU_W  = 4,
    parameter int RS_W   = 2
) (
    input  logic              en_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [CYC_W-1:0]  cycle_i,
    input  logic              carry_i,
    output logic              m_o,
    output logic              mw_o,
    output logic              mc_o,
    output logic              j_o,
    output logic              lj_o,
    output logic              cli_o,
    output logic              ljr_o,
    output logic              rd_o,
    output logic              wr_o,
    output logic              s_o,
    output logic              y_o,
    output logic              sei_o,
    output logic [RS_W-1:0]   rs_o,
    output logic [ALU_W-1:0]  alu_o
);

    logic [7:0] op;
    logic       c0, c1, simple;

    assign op     = inst_i[7:0];
    assign c0     = (cycle_i == CYC_W'(0));
    assign c1     = (cycle_i == CYC_W'(1));
    assign simple = (op[7:5] == CLS_SIMPLE);

    assign mc_o  = en_i & op[7] & c0;
    assign m_o   = en_i & op[7] & ~op[6] & c1;
    assign mw_o  = m_o & op[5];
    // Conditional jump is suppressed when op[4] selects carry and carry is set
    assign j_o   = en_i & (op[7:5] == CLS_JMP) & c1 & ~(op[4] & carry_i);
    assign lj_o  = en_i & simple & op[4] & ~op[3];
    assign cli_o = lj_o & op[1];
    assign ljr_o = lj_o & op[2];
    assign sei_o = lj_o & op[0] & ~op[1];
    assign rd_o  = en_i & simple & ~op[4] & op[2];
    assign wr_o  = en_i & simple & ~op[4] & op[3];
    assign s_o   = en_i & op[4];
    assign y_o   = en_i & op[5];
    assign rs_o  = en_i ? inst_i[RS_W-1:0]  : '0;
    assign alu_o = en_i ? inst_i[ALU_W-1:0] : '0;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction per handshake, steps it through
// its execute cycles, stretches memory cycles on mem_ready, and owns interrupt enable/pending.
module control_sequencer
    import control_pkg::*;
#(
    parameter int INST_W = 8,
    parameter int CYC_W  = 2,
    parameter int ALU_W  = 4,
    parameter int RS_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [INST_W-1:0] inst,
    input  logic              carry,
    input  logic              mem_ready,
    input  logic              irq,
    output logic [CYC_W-1:0]  cycle,
    output logic              busy,
    output logic              done,
    output logic              irq_take,
    output logic              M,
    output logic              MW,
    output logic              MC,
    output logic              J,
    output logic              LJ,
    output logic              CLI,
    output logic              LJR,
    output logic              RD,
    output logic              WR,
    output logic              S,
    output logic              Y,
    output logic [RS_W-1:0]   RS,
    output logic [ALU_W-1:0]  ALU
);

    state_e              state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [CYC_W-1:0]    cycle_q, cycle_d;
    logic                int_en_q, int_en_d;
    logic                irq_pend_q, irq_pend_d;
    logic [CYC_W-1:0]    last_cyc;
    logic                take_irq, mem_strb, sei;

    assign busy     = (state_q == EXEC) || (state_q == WAIT);
    assign cycle    = cycle_q;
    assign take_irq = (state_q == IDLE) & irq_pend_q & int_en_q;
    assign last_cyc = CYC_W'(cyc_len(inst_q[7:0]) - 1);
    assign mem_strb = MC | M;

    control_decode #(
        .INST_W (INST_W),
        .CYC_W  (CYC_W),
        .ALU_W  (ALU_W),
        .RS_W   (RS_W)
    ) u_decode (
        .en_i    (busy),
        .inst_i  (inst_q),
        .cycle_i (cycle_q),
        .carry_i (carry),
        .m_o     (M),
        .mw_o    (MW),
        .mc_o    (MC),
        .j_o     (J),
        .lj_o    (LJ),
        .cli_o   (CLI),
        .ljr_o   (LJR),
        .rd_o    (RD),
        .wr_o    (WR),
        .s_o     (S),
        .y_o     (Y),
        .sei_o   (sei),
        .rs_o    (RS),
        .alu_o   (ALU)
    );

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        cycle_d    = cycle_q;
        int_en_d   = int_en_q;
        irq_pend_d = irq_pend_q | irq;
        inst_ready = 1'b0;
        done       = 1'b0;
        irq_take   = 1'b0;
        case (state_q)
            IDLE: begin
                inst_ready = ~take_irq;
                if (take_irq) begin
                    state_d = IRQ;
                end else if (inst_valid) begin
                    inst_d  = inst;
                    cycle_d = '0;
                    state_d = EXEC;
                end
            end
            EXEC, WAIT: begin
                if (mem_strb && !mem_ready) begin
                    state_d = WAIT;
                end else if (cycle_q == last_cyc) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cycle_d = '0;
                    if (sei) int_en_d = 1'b1;
                    if (CLI) int_en_d = 1'b0;
                end else begin
                    cycle_d = cycle_q + CYC_W'(1);
                    state_d = EXEC;
                end
            end
            IRQ: begin
                // A still-asserted level request re-arms pending, but int_en is now off
                irq_take   = 1'b1;
                irq_pend_d = irq;
                int_en_d   = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inst_q     <= '0;
            cycle_q    <= '0;
            int_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            cycle_q    <= cycle_d;
            int_en_q   <= int_en_d;
            irq_pend_q <= irq_pend_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed strobe vectors for memory, jump,
// simple-op, interrupt and mid-instruction reset scenarios.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, inst_valid, carry, mem_ready, irq;
    logic [7:0]  inst;
    logic        inst_ready, busy, done, irq_take;
    logic [1:0]  cycle, RS;
    logic [3:0]  ALU;
    logic        M, MW, MC, J, LJ, CLI, LJR, RD, WR, S, Y;
    logic [10:0] strb;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Bit order: {M,MW,MC,J,LJ,CLI,LJR,RD,WR,S,Y}
    assign strb = {M, MW, MC, J, LJ, CLI, LJR, RD, WR, S, Y};

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .carry(carry), .mem_ready(mem_ready), .irq(irq),
        .cycle(cycle), .busy(busy), .done(done), .irq_take(irq_take),
        .M(M), .MW(MW), .MC(MC), .J(J), .LJ(LJ), .CLI(CLI), .LJR(LJR),
        .RD(RD), .WR(WR), .S(S), .Y(Y), .RS(RS), .ALU(ALU)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the edge; checks are taken 1 unit later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; inst_valid = 1'b0; inst = 8'h00; carry = 1'b0;
        mem_ready = 1'b1; irq = 1'b0;
        #1;
        chk("rst_ready", inst_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strb", strb, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Memory read 0x8C, no stall
        inst_valid = 1'b1; inst = 8'h8C; #1;
        chk("rd8c_ready", inst_ready, 1);
        tick(); inst_valid = 1'b0; #1;
        chk("rd8c_c0_strb", strb, 11'b001_0000_0000);
        chk("rd8c_c0_cyc", cycle, 0);
        chk("rd8c_c0_done", done, 0);
        chk("rd8c_alu", ALU, 4'hC);
        tick(); #1;
        chk("rd8c_c1_strb", strb, 11'b100_0000_0000);
        chk("rd8c_c1_cyc", cycle, 1);
        chk("rd8c_c1_done", done, 1);
        tick(); #1;
        chk("rd8c_idle_busy", busy, 0);
        chk("rd8c_idle_strb", strb, 0);
        chk("rd8c_idle_done", done, 0);

        // Memory write 0xA0 with three stalled clocks in cycle 1
        inst_valid = 1'b1; inst = 8'hA0; tick(); inst_valid = 1'b0; #1;
        chk("wra0_c0_strb", strb, 11'b001_0000_0001);
        tick(); mem_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ready = 1'b1; #1; end
            chk("wra0_c1_strb", strb, 11'b110_0000_0001);
            chk("wra0_c1_cyc", cycle, 1);
            chk("wra0_c1_done", done, (i == 3) ? 1 : 0);
            tick(); #1;
        end
        chk("wra0_end_busy", busy, 0);
        chk("wra0_end_done", done, 0);

        // Conditional jump 0xF0: carry set suppresses J, carry clear takes it
        for (int k = 0; k < 2; k++) begin
            carry = (k == 0);
            inst_valid = 1'b1; inst = 8'hF0; tick(); inst_valid = 1'b0; #1;
            chk("jf0_c0_strb", strb, 11'b001_0000_0011);
            tick(); #1;
            chk("jf0_c1_strb", strb, (k == 0) ? 11'b000_0000_0011 : 11'b000_1000_0011);
            chk("jf0_c1_done", done, 1);
            tick();
        end
        // Unconditional jump 0xE0 ignores carry
        carry = 1'b1;
        inst_valid = 1'b1; inst = 8'hE0; tick(); inst_valid = 1'b0; #1;
        chk("je0_c0_j", J, 0);
        tick(); #1;
        chk("je0_c1_strb", strb, 11'b000_1000_0001);
        tick(); carry = 1'b0;

        // SEI, then pending interrupt beats a simultaneous instruction
        inst_valid = 1'b1; inst = 8'h11; tick(); inst_valid = 1'b0; #1;
        chk("sei_strb", strb, 11'b000_0100_0010);
        chk("sei_done", done, 1);
        tick(); irq = 1'b1; #1;
        chk("sei_int_en", dut.int_en_q, 1);
        chk("irq_pre_ready", inst_ready, 1);
        tick(); irq = 1'b0; inst_valid = 1'b1; inst = 8'h0C; #1;
        chk("irq_blk_ready", inst_ready, 0);
        chk("irq_blk_take", irq_take, 0);
        tick(); #1;
        chk("irq_take", irq_take, 1);
        chk("irq_ready", inst_ready, 0);
        chk("irq_busy", busy, 0);
        tick(); #1;
        chk("irq_after_take", irq_take, 0);
        chk("irq_after_int_en", dut.int_en_q, 0);

        // Back-to-back 0x0C accepted every other clock
        for (int k = 0; k < 2; k++) begin
            chk("b2b_ready", inst_ready, 1);
            tick(); #1;
            chk("b2b_strb", strb, 11'b000_0000_1100);
            chk("b2b_alu", ALU, 4'hC);
            chk("b2b_done", done, 1);
            chk("b2b_busy_ready", inst_ready, 0);
            tick(); #1;
        end
        inst_valid = 1'b0;
        tick();

        // Re-enable interrupts, then reset in the middle of a memory write
        inst_valid = 1'b1; inst = 8'h11; tick(); inst_valid = 1'b0; tick();
        inst_valid = 1'b1; inst = 8'hA0; tick(); inst_valid = 1'b0; #1;
        chk("prerst_int_en", dut.int_en_q, 1);
        chk("prerst_strb", strb, 11'b001_0000_0001);
        rst_n = 1'b0; #1;
        chk("midrst_strb", strb, 0);
        chk("midrst_ready", inst_ready, 1);
        chk("midrst_int_en", dut.int_en_q, 0);
        chk("midrst_busy", busy, 0);
        tick(); #1;
        chk("postrst_done", done, 0);
        chk("postrst_strb", strb, 0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
